uart_tx: RTL and testbench

Serial transmit engine for the UART; consumes `TxStart`/`TxData` from the APB register block and returns `TxDone` to it. It serialises one character per request:
- start bit;
- 5–8 data bits, LSB first;
- optional parity;
- 1 or 2 stop bits.

Bit timing comes from an internal divisor counter loaded from `{ControlReg0[7:4], UBRR}`. The block drives the `Tx` pin directly.

---
 rtl/uart_pkg.sv | 43 ++++
 rtl/uart_baud_cnt.sv | 27 ++
 rtl/uart_tx.sv | 149 ++++++++++++++
 tb/tb_uart_tx.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter states, data-length and parity encodings,
// and the default baud divisor width used by both the Tx and Rx engines.
package uart_pkg;

    localparam int DIV_W = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    localparam logic [1:0] DLS_5 = 2'd0;
    localparam logic [1:0] DLS_6 = 2'd1;
    localparam logic [1:0] DLS_7 = 2'd2;
    localparam logic [1:0] DLS_8 = 2'd3;

    typedef enum logic {
        PARITY_ODD  = 1'b0,
        PARITY_EVEN = 1'b1
    } parity_t;

    // Bits above the selected character length must not reach the line or the parity.
    function automatic logic [7:0] data_mask(input logic [1:0] dls);
        logic [7:0] mask;
        case (dls)
            DLS_5:   mask = 8'h1F;
            DLS_6:   mask = 8'h3F;
            DLS_7:   mask = 8'h7F;
            DLS_8:   mask = 8'hFF;
            default: mask = 8'hFF;
        endcase
        return mask;
    endfunction

    function automatic logic [2:0] last_bit_index(input logic [1:0] dls);
        return 3'd4 + {1'b0, dls};
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period divisor: counts 0..term and pulses bit_tick on the terminal count.
// Shared by the transmit and receive engines.
module uart_baud_cnt #(
    parameter int DIV_W = uart_pkg::DIV_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [DIV_W-1:0] term,
    output logic             bit_tick
);

    logic [DIV_W-1:0] count;

    assign bit_tick = (count == term);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (bit_tick) begin
            count <= '0;
        end else begin
            count <= count + DIV_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART serial transmit engine: start bit, 5-8 data bits LSB first, optional
// parity and 1 or 2 stop bits, timed by a shadowed baud divisor.
module uart_tx #(
    parameter int DIV_W = uart_pkg::DIV_W
) (
    input  logic             pClk,
    input  logic             pReset,
    input  logic             TxEn,
    input  logic             TxStart,
    input  logic [7:0]       TxData,
    input  logic [DIV_W-1:0] UBRR,
    input  logic [1:0]       DLS,
    input  logic             STOP,
    input  logic             PEN,
    input  logic             EPS,
    output logic             Tx,
    output logic             TxBusy,
    output logic             TxDone
);

    import uart_pkg::*;

    tx_state_t        state;
    tx_state_t        next_state;

    logic [7:0]       shift_reg;
    logic [7:0]       masked_data;
    logic [1:0]       dls_q;
    logic             stop_q;
    logic             pen_q;
    logic             parity_q;
    logic [DIV_W-1:0] ubrr_q;
    logic [2:0]       bit_cnt;

    logic             bit_tick;
    logic             clear_div;
    logic             last_data;
    logic             last_stop;

    assign masked_data = TxData & data_mask(DLS);
    assign last_data   = (bit_cnt == last_bit_index(dls_q));
    assign last_stop   = (bit_cnt == {2'b00, stop_q});

    uart_baud_cnt #(
        .DIV_W(DIV_W)
    ) u_baud_cnt (
        .clk     (pClk),
        .reset   (pReset),
        .clear   (clear_div),
        .term    (ubrr_q),
        .bit_tick(bit_tick)
    );

    always_ff @(posedge pClk) begin
        if (pReset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Outputs decode only registered state, so TxDone never depends on TxStart.
    always_comb begin
        next_state = state;
        Tx         = 1'b1;
        TxBusy     = 1'b1;
        TxDone     = 1'b0;
        clear_div  = 1'b0;
        case (state)
            ST_IDLE: begin
                TxBusy    = 1'b0;
                clear_div = 1'b1;
                if (TxStart && TxEn) begin
                    next_state = ST_LOAD;
                end
            end
            ST_LOAD: begin
                clear_div  = 1'b1;
                next_state = ST_START;
            end
            ST_START: begin
                Tx = 1'b0;
                if (bit_tick) begin
                    next_state = ST_DATA;
                end
            end
            ST_DATA: begin
                Tx = shift_reg[0];
                if (bit_tick && last_data) begin
                    next_state = pen_q ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                Tx = parity_q;
                if (bit_tick) begin
                    next_state = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_tick && last_stop) begin
                    TxDone     = 1'b1;
                    next_state = (TxStart && TxEn) ? ST_LOAD : ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Shadow registers are written only in LOAD, so config edits mid-frame are harmless.
    always_ff @(posedge pClk) begin
        if (pReset) begin
            shift_reg <= '0;
            dls_q     <= DLS_5;
            stop_q    <= 1'b0;
            pen_q     <= 1'b0;
            parity_q  <= 1'b0;
            ubrr_q    <= '0;
            bit_cnt   <= '0;
        end else begin
            case (state)
                ST_LOAD: begin
                    shift_reg <= masked_data;
                    dls_q     <= DLS;
                    stop_q    <= STOP;
                    pen_q     <= PEN;
                    parity_q  <= (EPS == PARITY_EVEN) ? ^masked_data : ~^masked_data;
                    ubrr_q    <= UBRR;
                    bit_cnt   <= '0;
                end
                ST_DATA: begin
                    if (bit_tick) begin
                        shift_reg <= {1'b0, shift_reg[7:1]};
                        bit_cnt   <= last_data ? 3'd0 : bit_cnt + 3'd1;
                    end
                end
                ST_STOP: begin
                    if (bit_tick) begin
                        bit_cnt <= last_stop ? 3'd0 : bit_cnt + 3'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus queues hand-computed line sequences,
// a monitor checks every cycle of each frame the DUT presents on TxBusy.
module tb_uart_tx;

    logic        pClk = 1'b0;
    logic        pReset;
    logic        TxEn;
    logic        TxStart;
    logic [7:0]  TxData;
    logic [11:0] UBRR;
    logic [1:0]  DLS;
    logic        STOP;
    logic        PEN;
    logic        EPS;
    logic        Tx;
    logic        TxBusy;
    logic        TxDone;

    typedef struct {
        string seq;
        int    period;
        int    req_cycle;
    } exp_frame_t;

    exp_frame_t exp_q[$];
    int         checks = 0;
    int         fails = 0;
    int         cycle = 0;
    bit         in_frame = 1'b0;

    uart_tx #(
        .DIV_W(12)
    ) dut (
        .pClk   (pClk),
        .pReset (pReset),
        .TxEn   (TxEn),
        .TxStart(TxStart),
        .TxData (TxData),
        .UBRR   (UBRR),
        .DLS    (DLS),
        .STOP   (STOP),
        .PEN    (PEN),
        .EPS    (EPS),
        .Tx     (Tx),
        .TxBusy (TxBusy),
        .TxDone (TxDone)
    );

    always #5 pClk = ~pClk;

    always @(posedge pClk) cycle++;

    function automatic void check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cycle, actual, expected);
        end
    endfunction

    task automatic tick();
        @(posedge pClk);
        #1;
    endtask

    // TxData carries junk in the request cycle; the real character arrives for LOAD.
    task automatic apply_stimulus(input logic [7:0] data, input logic [1:0] dls, input logic stop,
                                  input logic pen, input logic eps, input logic [11:0] ubrr,
                                  input string seq);
        exp_frame_t e;
        TxData  = ~data;
        DLS     = dls;
        STOP    = stop;
        PEN     = pen;
        EPS     = eps;
        UBRR    = ubrr;
        TxStart = 1'b1;
        e.seq       = seq;
        e.period    = int'(ubrr) + 1;
        e.req_cycle = cycle;
        exp_q.push_back(e);
        tick();
        TxStart = 1'b0;
        TxData  = data;
    endtask

    task automatic wait_done(input int budget);
        bit got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            tick();
            if (TxDone) got = 1'b1;
        end
        check_output("wait_done", int'(got), 1);
    endtask

    initial begin : monitor
        exp_frame_t cur;
        int  k;
        int  fr_len;
        int  b;
        int  exp_tx;
        bit  rst_at_edge;
        bit  rogue = 1'b0;
        k = 0;
        fr_len = 0;
        forever begin
            @(posedge pClk);
            rst_at_edge = pReset;
            @(negedge pClk);
            if (rst_at_edge) begin
                in_frame = 1'b0;
                rogue    = 1'b0;
                check_output("reset_tx", int'(Tx), 1);
                check_output("reset_busy", int'(TxBusy), 0);
                check_output("reset_done", int'(TxDone), 0);
            end else if (rogue) begin
                if (!TxBusy) rogue = 1'b0;
            end else if (!in_frame) begin
                if (TxBusy) begin
                    if (exp_q.size() == 0) begin
                        check_output("spurious_frame", 1, 0);
                        rogue = 1'b1;
                    end else begin
                        cur      = exp_q.pop_front();
                        in_frame = 1'b1;
                        k        = 1;
                        fr_len   = cur.seq.len() * cur.period;
                        check_output("load_cycle", cycle, cur.req_cycle + 1);
                        check_output("load_tx", int'(Tx), 1);
                        check_output("load_done", int'(TxDone), 0);
                    end
                end else begin
                    check_output("idle_tx", int'(Tx), 1);
                    check_output("idle_done", int'(TxDone), 0);
                end
            end else begin
                k++;
                b = (k - 2) / cur.period;
                exp_tx = (cur.seq[b] == "1") ? 1 : 0;
                check_output("frame_tx", int'(Tx), exp_tx);
                check_output("frame_busy", int'(TxBusy), 1);
                check_output("frame_done", int'(TxDone), (k == fr_len + 1) ? 1 : 0);
                if (k == fr_len + 1) in_frame = 1'b0;
            end
        end
    end

    initial begin : stimulus
        pReset  = 1'b1;
        TxEn    = 1'b1;
        TxStart = 1'b0;
        TxData  = 8'h00;
        UBRR    = 12'd0;
        DLS     = 2'd3;
        STOP    = 1'b0;
        PEN     = 1'b0;
        EPS     = 1'b0;
        repeat (3) tick();
        pReset = 1'b0;
        repeat (2) tick();

        // 8N1, 0xA5, 4-cycle bits
        apply_stimulus(8'hA5, 2'd3, 1'b0, 1'b0, 1'b0, 12'd3, "0101001011");
        wait_done(60);
        repeat (2) tick();

        // 5 bits even parity, 2 stop bits, 1-cycle bits
        apply_stimulus(8'hFF, 2'd0, 1'b1, 1'b1, 1'b1, 12'd0, "011111111");
        wait_done(20);
        repeat (2) tick();

        // 7 bits odd parity of 0x03 -> parity 1
        apply_stimulus(8'h03, 2'd2, 1'b0, 1'b1, 1'b0, 12'd1, "0110000011");
        wait_done(40);
        repeat (2) tick();

        // Chaining: second request lands in the TxDone cycle
        apply_stimulus(8'h3C, 2'd3, 1'b0, 1'b0, 1'b0, 12'd1, "0001111001");
        wait_done(40);
        apply_stimulus(8'h81, 2'd3, 1'b0, 1'b0, 1'b0, 12'd1, "0100000011");
        wait_done(40);
        repeat (2) tick();

        // Requests during DATA, config edits and TxEn drop mid-frame are ignored
        apply_stimulus(8'h5A, 2'd3, 1'b0, 1'b0, 1'b0, 12'd2, "0010110101");
        repeat (8) tick();
        TxStart = 1'b1;
        TxData  = 8'hFF;
        tick();
        TxStart = 1'b0;
        UBRR    = 12'd0;
        DLS     = 2'd0;
        TxEn    = 1'b0;
        wait_done(60);
        repeat (2) tick();
        TxStart = 1'b1;
        tick();
        TxStart = 1'b0;
        repeat (10) tick();
        TxEn = 1'b1;

        // Reset in the middle of DATA abandons the frame
        apply_stimulus(8'hC3, 2'd3, 1'b0, 1'b0, 1'b0, 12'd3, "0110000111");
        repeat (12) tick();
        pReset = 1'b1;
        tick();
        pReset = 1'b0;
        repeat (3) tick();

        // Fresh frame after reset: 0x96, even parity -> 0
        apply_stimulus(8'h96, 2'd3, 1'b0, 1'b1, 1'b1, 12'd1, "00110100101");
        wait_done(40);
        repeat (5) tick();

        check_output("queue_drained", exp_q.size() + int'(in_frame), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
